ring_drain_tx: RTL and testbench

- Consumer end of the BLE receive ring buffer held in servant_ram.
- The RX path writes one byte per 32-bit word at increasing addresses within [ADR_LL, ADR_UL].
- This block reads those words back over a Wishbone master port and serialises byte [7:0] of each word on a UART 8N1 line.
- It sits beside the RX writer and shares the RAM through the same address/cyc/we mux.

---
 rtl/ring_pkg.sv | 24 ++
 rtl/ring_drain_baud.sv | 27 ++
 rtl/ring_drain_tx.sv | 161 ++++++++++++++++
 tb/tb_ring_drain_tx.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared ring-buffer definitions: drain FSM states, pointer advance, default ring bounds.
package ring_pkg;

    localparam logic [31:0] ADR_LL_DEF       = 32'h0000_0300;
    localparam logic [31:0] ADR_UL_DEF       = 32'h0000_1FFC;
    localparam int unsigned CLKS_PER_BIT_DEF = 104;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    // Word-pointer advance shared by the writer and the drain so both wrap identically.
    function automatic logic [31:0] ring_next(input logic [31:0] ptr,
                                              input logic [31:0] ll,
                                              input logic [31:0] ul);
        return (ptr >= ul) ? ll : ptr + 32'd4;
    endfunction

endpackage

// File: rtl/ring_drain_baud.sv
// Bit-period timer: reloads to CLKS_PER_BIT-1 on load or on expiry; tick_c marks the last cycle of a bit.
module ring_drain_baud #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tick_c
);

    localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load || (cnt_q == '0)) begin
            cnt_q <= CW'(CLKS_PER_BIT - 1);
        end else begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign tick_c = (cnt_q == '0);

endmodule

// File: rtl/ring_drain_tx.sv
// Ring-buffer drain: reads one byte per word over Wishbone and sends it as a UART frame.
// Build option RING_DRAIN_PARITY_EN adds an even-parity bit between data and stop.
module ring_drain_tx
    import ring_pkg::*;
#(
    parameter logic [31:0] ADR_LL       = ADR_LL_DEF,
    parameter logic [31:0] ADR_UL       = ADR_UL_DEF,
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic        i_en,
    input  logic [31:0] i_wr_ptr,
    output logic [31:0] o_rd_ptr,
    output logic [31:0] o_wb_adr,
    output logic        o_wb_cyc,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_tx,
    output logic        o_busy
);

    state_t      state_q, state_nx;
    logic [31:0] rd_ptr_nx, adr_nx;
    logic        cyc_nx, tx_nx, busy_nx;
    logic [2:0]  bit_cnt_q, bit_cnt_nx;
    logic [7:0]  shift_q, shift_nx;
    logic        load_c, tick_c;
`ifdef RING_DRAIN_PARITY_EN
    logic        par_q, par_nx;
`endif
    logic        rdt_unused;

    assign o_wb_we    = 1'b0;
    assign o_wb_sel   = 4'b1111;
    assign rdt_unused = ^i_wb_rdt[31:8];

    ring_drain_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (i_wb_clk),
        .rst_n  (i_wb_rst_n),
        .load   (load_c),
        .tick_c (tick_c)
    );

    // State register and all registered outputs.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q   <= IDLE;
            o_rd_ptr  <= ADR_LL;
            o_wb_adr  <= ADR_LL;
            o_wb_cyc  <= 1'b0;
            o_tx      <= 1'b1;
            o_busy    <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
`ifdef RING_DRAIN_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_nx;
            o_rd_ptr  <= rd_ptr_nx;
            o_wb_adr  <= adr_nx;
            o_wb_cyc  <= cyc_nx;
            o_tx      <= tx_nx;
            o_busy    <= busy_nx;
            bit_cnt_q <= bit_cnt_nx;
            shift_q   <= shift_nx;
`ifdef RING_DRAIN_PARITY_EN
            par_q     <= par_nx;
`endif
        end
    end

    // Next-state and next-output logic; the line level is set one edge ahead of each state.
    always_comb begin
        state_nx   = state_q;
        rd_ptr_nx  = o_rd_ptr;
        adr_nx     = o_wb_adr;
        cyc_nx     = o_wb_cyc;
        tx_nx      = o_tx;
        bit_cnt_nx = bit_cnt_q;
        shift_nx   = shift_q;
        load_c     = 1'b0;
`ifdef RING_DRAIN_PARITY_EN
        par_nx     = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (i_en && (o_rd_ptr != i_wr_ptr)) begin
                    state_nx = FETCH;
                    cyc_nx   = 1'b1;
                    adr_nx   = o_rd_ptr;
                end
            end
            FETCH: begin
                if (i_wb_ack) begin
                    shift_nx   = i_wb_rdt[7:0];
`ifdef RING_DRAIN_PARITY_EN
                    par_nx     = ^i_wb_rdt[7:0];
`endif
                    cyc_nx     = 1'b0;
                    rd_ptr_nx  = ring_next(o_rd_ptr, ADR_LL, ADR_UL);
                    bit_cnt_nx = '0;
                    tx_nx      = 1'b0;
                    load_c     = 1'b1;
                    state_nx   = START;
                end
            end
            START: begin
                if (tick_c) begin
                    tx_nx    = shift_q[0];
                    shift_nx = shift_q >> 1;
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (tick_c) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef RING_DRAIN_PARITY_EN
                        tx_nx    = par_q;
                        state_nx = PARITY;
`else
                        tx_nx    = 1'b1;
                        state_nx = STOP;
`endif
                    end else begin
                        bit_cnt_nx = bit_cnt_q + 3'd1;
                        tx_nx      = shift_q[0];
                        shift_nx   = shift_q >> 1;
                    end
                end
            end
`ifdef RING_DRAIN_PARITY_EN
            PARITY: begin
                if (tick_c) begin
                    tx_nx    = 1'b1;
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                if (tick_c) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cyc_nx   = 1'b0;
                tx_nx    = 1'b1;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_ring_drain_tx.sv
// Bench for ring_drain_tx: RAM/ack model, frame capture, per-scenario checks against a ring model.
module tb_ring_drain_tx;

    localparam logic [31:0] LL    = 32'h0000_0300;
    localparam logic [31:0] UL    = 32'h0000_031C;
    localparam int unsigned CPB   = 4;
    localparam int          NSLOT = 8;
`ifdef RING_DRAIN_PARITY_EN
    localparam int          NB    = 11;
`else
    localparam int          NB    = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] wr_ptr;
    logic [31:0] rd_ptr;
    logic [31:0] wb_adr;
    logic        wb_cyc;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic        tx;
    logic        busy;

    int          checks   = 0;
    int          failures = 0;

    logic [31:0] mem [NSLOT];
    int          ack_lat  = 2;
    bit          stray_en = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] rd_log [$];
    logic [31:0] exp_ptr;

    ring_drain_tx #(
        .ADR_LL      (LL),
        .ADR_UL      (UL),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .i_wb_clk  (clk),
        .i_wb_rst_n(rst_n),
        .i_en      (en),
        .i_wr_ptr  (wr_ptr),
        .o_rd_ptr  (rd_ptr),
        .o_wb_adr  (wb_adr),
        .o_wb_cyc  (wb_cyc),
        .o_wb_we   (wb_we),
        .o_wb_sel  (wb_sel),
        .i_wb_rdt  (wb_rdt),
        .i_wb_ack  (wb_ack),
        .o_tx      (tx),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic int slot(input logic [31:0] a);
        return int'(((a - LL) >> 2) % 32'(NSLOT));
    endfunction

    // Ring arithmetic from first principles: modular offset within the ring.
    function automatic logic [31:0] model_next(input logic [31:0] p);
        return LL + ((p - LL + 32'd4) % (UL - LL + 32'd4));
    endfunction

    // Expected line levels, index 0 = start bit.
    function automatic logic [NB-1:0] exp_bits(input logic [7:0] d);
`ifdef RING_DRAIN_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    // RAM slave: ack after ack_lat cycles of cyc; optional stray acks while cyc is low.
    always @(negedge clk) begin
        if (!wb_cyc) begin
            wait_cnt = 0;
            wb_ack   = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
            wb_rdt   = $urandom;
        end else begin
            if (wait_cnt == 0) wb_ack = 1'b0;
            wait_cnt++;
            if (wait_cnt >= ack_lat) begin
                wb_ack = 1'b1;
                wb_rdt = mem[slot(wb_adr)];
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && wb_cyc && wb_ack) rd_log.push_back(wb_adr);
    end

    // Line monitor: waits for a start edge, samples every cycle of each bit (X if it wobbles).
    task automatic capture_frame(output logic [NB-1:0] bits, output int gap,
                                 output int busy_low, output logic busy_after,
                                 output bit timeout);
        logic lvl;
        gap = 0; busy_low = 0; timeout = 1'b1; bits = 'x; busy_after = 1'bx; lvl = 1'bx;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                timeout = 1'b0;
                break;
            end
            gap++;
            if (busy === 1'b0) busy_low++;
        end
        if (timeout) return;
        for (int k = 0; k < NB; k++) begin
            for (int c = 0; c < int'(CPB); c++) begin
                if (!(k == 0 && c == 0)) @(negedge clk);
                if (c == 0) lvl = tx;
                else if (tx !== lvl) lvl = 1'bx;
            end
            bits[k] = lvl;
        end
        @(negedge clk);
        busy_after = busy;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; wr_ptr = LL;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx, wb_cyc, busy, wb_we, wb_sel} !== 8'b1000_1111) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=%b", {tx, wb_cyc, busy, wb_we, wb_sel}, 8'b1000_1111);
        end
        checks++;
        if (rd_ptr !== LL) begin
            failures++;
            $display("FAIL reset_rd_ptr got=%h exp=%h", rd_ptr, LL);
        end
        checks++;
        if (wb_adr !== LL) begin
            failures++;
            $display("FAIL reset_adr got=%h exp=%h", wb_adr, LL);
        end
        rst_n = 1'b1;
        exp_ptr = LL;
        @(negedge clk);
    endtask

    task automatic test_empty;
        bit saw_cyc = 1'b0, saw_low = 1'b0, saw_busy = 1'b0;
        wr_ptr = LL; en = 1'b1; stray_en = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (wb_cyc !== 1'b0) saw_cyc = 1'b1;
            if (tx !== 1'b1) saw_low = 1'b1;
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        stray_en = 1'b0;
        checks++;
        if (saw_cyc) begin failures++; $display("FAIL empty_cyc got=1 exp=0"); end
        checks++;
        if (saw_low) begin failures++; $display("FAIL empty_tx got=0 exp=1"); end
        checks++;
        if (saw_busy) begin failures++; $display("FAIL empty_busy got=1 exp=0"); end
    endtask

    task automatic test_single_byte;
        logic [NB-1:0] bits;
        int gap, bl;
        logic ba;
        bit to;
        ack_lat = 2;
        mem[0] = 32'hFFFF_FF55;
        rd_log.delete();
        wr_ptr = LL + 32'd4;
        capture_frame(bits, gap, bl, ba, to);
        checks++;
        if (to || bits !== exp_bits(8'h55)) begin
            failures++;
            $display("FAIL single_bits got=%b exp=%b timeout=%0d", bits, exp_bits(8'h55), to);
        end
        checks++;
        if (gap != ack_lat) begin
            failures++;
            $display("FAIL single_start_latency got=%0d exp=%0d", gap, ack_lat);
        end
        checks++;
        if (ba !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_end got=%b exp=0", ba);
        end
        checks++;
        if (rd_log.size() != 1 || rd_log[0] !== LL) begin
            failures++;
            $display("FAIL single_reads got_n=%0d first=%h exp=%h", rd_log.size(),
                     (rd_log.size() > 0) ? rd_log[0] : 32'hx, LL);
        end
        exp_ptr = LL + 32'd4;
        checks++;
        if (rd_ptr !== exp_ptr) begin
            failures++;
            $display("FAIL single_rd_ptr got=%h exp=%h", rd_ptr, exp_ptr);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [3];
        logic [NB-1:0] bits;
        int gap, bl;
        logic ba;
        bit to;
        logic [31:0] p;
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'h01;
        ack_lat = $urandom_range(1, 3);
        p = exp_ptr;
        for (int i = 0; i < 3; i++) begin
            mem[slot(p)] = {24'($urandom), bytes[i]};
            p = model_next(p);
        end
        rd_log.delete();
        wr_ptr = p;
        for (int i = 0; i < 3; i++) begin
            capture_frame(bits, gap, bl, ba, to);
            checks++;
            if (to || bits !== exp_bits(bytes[i])) begin
                failures++;
                $display("FAIL b2b_bits%0d got=%b exp=%b", i, bits, exp_bits(bytes[i]));
            end
            if (i > 0) begin
                checks++;
                if (gap != ack_lat || bl != 0) begin
                    failures++;
                    $display("FAIL b2b_gap%0d got_fetch=%0d exp=%0d extra_idle=%0d", i, gap, ack_lat, bl);
                end
            end
            checks++;
            if (ba !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle%0d got_busy=%b exp=0", i, ba);
            end
        end
        checks++;
        if (rd_log.size() != 3 || rd_log[0] !== exp_ptr || rd_log[1] !== model_next(exp_ptr)
            || rd_log[2] !== model_next(model_next(exp_ptr))) begin
            failures++;
            $display("FAIL b2b_reads got_n=%0d exp_first=%h", rd_log.size(), exp_ptr);
        end
        exp_ptr = p;
        checks++;
        if (rd_ptr !== exp_ptr) begin
            failures++;
            $display("FAIL b2b_rd_ptr got=%h exp=%h", rd_ptr, exp_ptr);
        end
    endtask

    task automatic test_enable_drop;
        logic [NB-1:0] bits;
        int gap, bl;
        logic ba;
        bit to;
        bit saw;
        logic [31:0] p0, p1;
        p0 = exp_ptr; p1 = model_next(p0);
        mem[slot(p0)] = $urandom; mem[slot(p1)] = $urandom;
        ack_lat = 1;
        wr_ptr = model_next(p1);
        fork
            capture_frame(bits, gap, bl, ba, to);
            begin
                repeat (3 + 3 * CPB) @(negedge clk);
                en = 1'b0;
            end
        join
        checks++;
        if (to || bits !== exp_bits(mem[slot(p0)][7:0])) begin
            failures++;
            $display("FAIL endrop_frame got=%b exp=%b", bits, exp_bits(mem[slot(p0)][7:0]));
        end
        saw = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (wb_cyc !== 1'b0 || tx !== 1'b1) saw = 1'b1;
        end
        checks++;
        if (saw || rd_ptr !== p1) begin
            failures++;
            $display("FAIL endrop_hold got_activity=%0d rd_ptr=%h exp=%h", saw, rd_ptr, p1);
        end
        en = 1'b1;
        capture_frame(bits, gap, bl, ba, to);
        checks++;
        if (to || bits !== exp_bits(mem[slot(p1)][7:0])) begin
            failures++;
            $display("FAIL endrop_resume got=%b exp=%b", bits, exp_bits(mem[slot(p1)][7:0]));
        end
        exp_ptr = model_next(p1);
    endtask

    task automatic test_wrap;
        logic [NB-1:0] bits;
        int gap, bl, n;
        logic ba;
        bit to;
        logic [31:0] p;
        p = exp_ptr; n = 0;
        while (p != UL && n < NSLOT) begin
            mem[slot(p)] = $urandom;
            p = model_next(p);
            n++;
        end
        wr_ptr = UL;
        for (int i = 0; i < n; i++) begin
            capture_frame(bits, gap, bl, ba, to);
            checks++;
            if (to || bits !== exp_bits(mem[slot(exp_ptr)][7:0])) begin
                failures++;
                $display("FAIL wrap_drain%0d got=%b exp=%b", i, bits, exp_bits(mem[slot(exp_ptr)][7:0]));
            end
            exp_ptr = model_next(exp_ptr);
        end
        mem[slot(UL)] = $urandom; mem[slot(LL)] = $urandom;
        rd_log.delete();
        @(negedge clk);
        wr_ptr = LL + 32'd4;
        for (int i = 0; i < 2; i++) begin
            logic [7:0] d;
            d = (i == 0) ? mem[slot(UL)][7:0] : mem[slot(LL)][7:0];
            capture_frame(bits, gap, bl, ba, to);
            checks++;
            if (to || bits !== exp_bits(d)) begin
                failures++;
                $display("FAIL wrap_frame%0d got=%b exp=%b", i, bits, exp_bits(d));
            end
        end
        checks++;
        if (rd_log.size() != 2 || rd_log[0] !== UL || rd_log[1] !== LL) begin
            failures++;
            $display("FAIL wrap_reads got_n=%0d exp=%h,%h", rd_log.size(), UL, LL);
        end
        exp_ptr = LL + 32'd4;
        checks++;
        if (rd_ptr !== exp_ptr) begin
            failures++;
            $display("FAIL wrap_rd_ptr got=%h exp=%h", rd_ptr, exp_ptr);
        end
    endtask

    task automatic test_random;
        logic [NB-1:0] bits;
        int gap, bl, n, bad;
        logic ba;
        bit to;
        logic [31:0] wp;
        logic [31:0] exp_q [$];
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, 4);
            ack_lat = $urandom_range(1, 3);
            stray_en = 1'($urandom_range(0, 1));
            exp_q.delete();
            wp = exp_ptr;
            for (int i = 0; i < n; i++) begin
                mem[slot(wp)] = $urandom;
                exp_q.push_back(wp);
                wp = model_next(wp);
            end
            rd_log.delete();
            @(negedge clk);
            wr_ptr = wp;
            bad = 0;
            for (int i = 0; i < n; i++) begin
                capture_frame(bits, gap, bl, ba, to);
                if (to || bits !== exp_bits(mem[slot(exp_q[i])][7:0])) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL rand%0d_frames bad=%0d of %0d exp=0", r, bad, n);
            end
            checks++;
            if (rd_log.size() != n || rd_log != exp_q || rd_ptr !== wp) begin
                failures++;
                $display("FAIL rand%0d_reads got_n=%0d exp_n=%0d rd_ptr=%h exp=%h",
                         r, rd_log.size(), n, rd_ptr, wp);
            end
            exp_ptr = wp;
        end
        stray_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [NB-1:0] bits;
        int gap, bl;
        logic ba;
        bit to, found, saw;
        mem[slot(exp_ptr)] = $urandom;
        ack_lat = 2;
        wr_ptr = model_next(exp_ptr);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin found = 1'b1; break; end
        end
        repeat (4 * CPB) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!found || {tx, wb_cyc, busy} !== 3'b100) begin
            failures++;
            $display("FAIL rstmid_ctrl got=%b exp=100 started=%0d", {tx, wb_cyc, busy}, found);
        end
        checks++;
        if (rd_ptr !== LL) begin
            failures++;
            $display("FAIL rstmid_rd_ptr got=%h exp=%h", rd_ptr, LL);
        end
        @(negedge clk);
        wr_ptr = LL; en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (wb_cyc !== 1'b0 || tx !== 1'b1) saw = 1'b1;
        end
        en = 1'b0; wr_ptr = LL + 32'd4;
        repeat (30) begin
            @(negedge clk);
            if (wb_cyc !== 1'b0 || tx !== 1'b1) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            failures++;
            $display("FAIL rstmid_quiet got_activity=1 exp=0");
        end
        mem[0] = $urandom;
        en = 1'b1;
        capture_frame(bits, gap, bl, ba, to);
        checks++;
        if (to || bits !== exp_bits(mem[0][7:0]) || rd_ptr !== LL + 32'd4) begin
            failures++;
            $display("FAIL rstmid_restart got=%b exp=%b rd_ptr=%h", bits, exp_bits(mem[0][7:0]), rd_ptr);
        end
    endtask

    initial begin
        for (int i = 0; i < NSLOT; i++) mem[i] = 32'h0;
        test_reset();
        test_empty();
        test_single_byte();
        test_back_to_back();
        test_enable_drop();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time_limit_reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
